// File: rtl/rs_encode_stream.sv
// Systematic Reed-Solomon encoder, GF(2^SYM_W), streaming valid/ready, one output register stage.
// Optional build macro RS_SHORTEN_EN adds a per-codeword k_len input for shortened codewords.
`default_nettype none

module rs_encode_stream #(
  parameter int SYM_W = 4,
  parameter int N     = 15,
  parameter int K     = 9,
  parameter logic [SYM_W:0]           PRIM_POLY = 5'b10011,
  parameter logic [(N-K)*SYM_W-1:0]   GEN_COEF  = 24'h793CAC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
`ifdef RS_SHORTEN_EN
  input  logic [$clog2(K+1)-1:0] k_len,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SYM_W-1:0]   out_data,
  output logic               out_parity,
  output logic               out_last,
  output logic               busy
);

  localparam int NP = N - K;
  localparam int LW = NP * SYM_W;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MSG  = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;

  function automatic logic [SYM_W-1:0] gmul(input logic [SYM_W-1:0] a,
                                            input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
    end
    return acc;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [LW-1:0]    lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_data_q, out_data_d;
  logic             out_parity_q, out_parity_d;
  logic             out_last_q, out_last_d;

  logic             slot_free;
  logic             accept;
  logic [SYM_W-1:0] fb;
  logic [LW-1:0]    gprod;
  logic [CW-1:0]    cur_len;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != S_PAR) && slot_free;
  assign accept    = in_valid && in_ready;
  assign fb        = in_data ^ lfsr_q[LW-1 -: SYM_W];

  always_comb begin
    gprod = '0;
    for (int i = 0; i < NP; i++)
      gprod[i*SYM_W +: SYM_W] = gmul(fb, GEN_COEF[i*SYM_W +: SYM_W]);
  end

`ifdef RS_SHORTEN_EN
  localparam int KW = $clog2(K + 1);
  logic [CW-1:0] mlen_q, mlen_d;
  logic [CW-1:0] klen_eff;
  // Out-of-range lengths fall back to the full message length.
  assign klen_eff = (k_len == '0 || k_len > KW'(K)) ? CW'(K) : CW'(k_len);
  assign cur_len  = (state_q == S_IDLE) ? klen_eff : mlen_q;
`else
  assign cur_len  = CW'(K);
`endif

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_parity_d = out_valid_d ? out_parity_q : 1'b0;
    out_last_d   = out_valid_d ? out_last_q : 1'b0;
`ifdef RS_SHORTEN_EN
    mlen_d       = mlen_q;
`endif
    if (clr) begin
      state_d      = S_IDLE;
      lfsr_d       = '0;
      cnt_d        = '0;
      out_valid_d  = 1'b0;
      out_parity_d = 1'b0;
      out_last_d   = 1'b0;
    end else if (accept) begin
      lfsr_d       = (lfsr_q << SYM_W) ^ gprod;
      out_data_d   = in_data;
      out_valid_d  = 1'b1;
      out_parity_d = 1'b0;
      out_last_d   = 1'b0;
`ifdef RS_SHORTEN_EN
      if (state_q == S_IDLE) mlen_d = klen_eff;
`endif
      if (cnt_q + CW'(1) == cur_len) begin
        state_d = S_PAR;
        cnt_d   = '0;
      end else begin
        state_d = S_MSG;
        cnt_d   = cnt_q + CW'(1);
      end
    end else if (state_q == S_PAR && slot_free) begin
      out_data_d   = lfsr_q[LW-1 -: SYM_W];
      out_valid_d  = 1'b1;
      out_parity_d = 1'b1;
      lfsr_d       = lfsr_q << SYM_W;
      // Returning to IDLE as the last parity enters the output register lets
      // the next codeword start the same cycle that parity is consumed.
      if (cnt_q == CW'(NP - 1)) begin
        out_last_d = 1'b1;
        state_d    = S_IDLE;
        cnt_d      = '0;
        lfsr_d     = '0;
      end else begin
        out_last_d = 1'b0;
        cnt_d      = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
`ifdef RS_SHORTEN_EN
      mlen_q       <= CW'(K);
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
`ifdef RS_SHORTEN_EN
      mlen_q       <= mlen_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rs_encode_stream.sv
// Bench for rs_encode_stream (RS(15,9), GF(16)): vector table plus scoreboard, with reset/clr corner cases.
`default_nettype none

module tb_rs_encode_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic       out_parity;
  logic       out_last;
  logic       busy;
`ifdef RS_SHORTEN_EN
  logic [3:0] k_len = 4'd0;
`endif

  always #5 clk = ~clk;

  rs_encode_stream dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
`ifdef RS_SHORTEN_EN
    .k_len      (k_len),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_last   (out_last),
    .busy       (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent GF(16) model via log/antilog tables and polynomial long division.
  logic [3:0] gexp [15];
  int         glog [16];

  function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  function automatic logic [23:0] rs_par(input logic [35:0] m);
    logic [3:0]  c [15];
    logic [3:0]  gg [7];
    logic [27:0] gpoly;
    logic [3:0]  coef;
    logic [23:0] r;
    gpoly = 28'h1793CAC;
    for (int j = 0; j < 7; j++) gg[j] = gpoly[4*j +: 4];
    for (int j = 0; j < 15; j++) c[j] = 4'h0;
    for (int k = 0; k < 9; k++) c[14-k] = m[4*(8-k) +: 4];
    for (int d = 14; d >= 6; d--) begin
      coef = c[d];
      for (int j = 0; j < 7; j++) c[d-6+j] = c[d-6+j] ^ gm(coef, gg[j]);
    end
    for (int j = 0; j < 6; j++) r[4*j +: 4] = c[j];
    return r;
  endfunction

  typedef struct packed {
    logic [3:0] d;
    logic       p;
    logic       l;
  } exp_t;
  exp_t sb [$];
  exp_t e_mon;

  typedef struct packed {
    logic [35:0] msg;
    logic [23:0] par;
    logic        rmode;
  } vec_t;
  vec_t vt [6];

  logic rmode = 1'b0;

  // Monitor: pops the scoreboard on every output handshake and checks held data under stall.
  logic       prev_stall = 1'b0;
  logic [5:0] prev_out = '0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {25'd0, out_valid, out_data, out_parity, out_last},
              {25'd0, 1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {26'd0, out_data, out_parity, out_last}, 32'hFFFF_FFFF);
        end else begin
          e_mon = sb.pop_front();
          check("codeword_sym", {26'd0, out_data, out_parity, out_last},
                {26'd0, e_mon.d, e_mon.p, e_mon.l});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_parity, out_last};
    end
  end

  task automatic drive_word(input logic [35:0] m, input int len, input logic [23:0] par,
                            output int lows);
    int i;
    int guard;
    lows  = 0;
    i     = 9 - len;
    guard = 0;
    while (i < 9 && guard < 300) begin
      @(negedge clk);
      out_ready = (rmode == 1'b0) ? 1'b1 : ~out_ready;
      in_valid  = 1'b1;
      in_data   = m[4*(8-i) +: 4];
      #1;
      if (in_ready) begin
        sb.push_back('{d: in_data, p: 1'b0, l: 1'b0});
        i++;
      end else begin
        lows++;
      end
      guard++;
    end
    if (i < 9) check("drive_timeout", 32'(i), 32'd9);
    for (int j = 0; j < 6; j++)
      sb.push_back('{d: par[4*(5-j) +: 4], p: 1'b1, l: (j == 5)});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = (rmode == 1'b0) ? 1'b1 : ~out_ready;
      #1;
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int   lows;
    int   guard;
    logic [63:0] rnd;

    gexp[0] = 4'h1;
    glog[0] = 0;
    glog[1] = 0;
    for (int i = 1; i < 15; i++) begin
      logic [4:0] t;
      t = {gexp[i-1], 1'b0};
      if (t[4]) t = t ^ 5'h13;
      gexp[i] = t[3:0];
      glog[t[3:0]] = i;
    end

    vt[0] = '{msg: 36'h0,         par: 24'h000000, rmode: 1'b0};
    vt[1] = '{msg: 36'h000000001, par: 24'h793CAC, rmode: 1'b0};
    vt[2] = '{msg: 36'h000000001, par: 24'h793CAC, rmode: 1'b1};
    for (int i = 3; i < 6; i++) begin
      rnd = {$urandom(), $urandom()};
      vt[i].msg   = rnd[35:0];
      vt[i].par   = rs_par(rnd[35:0]);
      vt[i].rmode = (i == 4);
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},   32'd1);
    check("rst_out_valid", {31'd0, out_valid},  32'd0);
    check("rst_out_data",  {28'd0, out_data},   32'd0);
    check("rst_flags",     {29'd0, out_parity, out_last, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      rmode = vt[i].rmode;
      out_ready = 1'b1;
      drive_word(vt[i].msg, 9, vt[i].par, lows);
      if (vt[i].rmode == 1'b0) check("idle_start_lows", 32'(lows), 32'd0);
      drain();
    end
    rmode = 1'b0;

    // Back-to-back codewords with in_valid held high
    drive_word(36'h000000001, 9, 24'h793CAC, lows);
    drive_word(36'h000000001, 9, 24'h793CAC, lows);
    check("b2b_ready_low_w2", 32'(lows), 32'd6);
    drive_word(36'h000000001, 9, 24'h793CAC, lows);
    check("b2b_ready_low_w3", 32'(lows), 32'd6);
    drain();

    // Async reset during the third parity symbol
    drive_word(36'h000000001, 9, 24'h793CAC, lows);
    guard = 0;
    do begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #3;
      guard++;
    end while (!(out_valid && out_parity && out_data == 4'h3) && guard < 30);
    check("rst_mid_reach_p3", {31'd0, out_valid && out_parity && out_data == 4'h3}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy",      {31'd0, busy},      32'd0);
    check("rst_mid_out_last",  {31'd0, out_last},  32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_word(36'h0, 9, 24'h000000, lows);
    drain();

    // clr mid-message, with a competing accept in the same cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'(i + 5);
      #1;
      if (in_ready) sb.push_back('{d: in_data, p: 1'b0, l: 1'b0});
    end
    @(negedge clk);
    #1;
    check("clr_pre_busy", {31'd0, busy}, 32'd1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_busy",      {31'd0, busy},      32'd0);
    check("clr_in_ready",  {31'd0, in_ready},  32'd1);
    sb.delete();
    drive_word(36'h000000001, 9, 24'h793CAC, lows);
    drain();

`ifdef RS_SHORTEN_EN
    // Shortened codeword: one message symbol, parity count unchanged
    k_len = 4'd1;
    drive_word(36'h000000001, 1, 24'h793CAC, lows);
    k_len = 4'd5;
    drain();
    k_len = 4'd0;
    drive_word(vt[3].msg, 9, vt[3].par, lows);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
